program_loader: RTL

- Byte-stream writer that fills the two byte-wide data memory banks before or between program runs.
- Bank 1 holds the upper byte and bank 2 holds the lower byte; both share one address.
- Accepts a framed byte stream (sync, address, length, payload) over a valid/ready handshake and issues one bank write per payload byte.
- Asserts a CPU-hold output while a frame is in progress. The top level ORs this into master reset, so the core restarts from a freshly loaded image.

---
 rtl/program_loader_pkg.sv | 34 +++
 rtl/loader_write_port.sv | 34 +++
 rtl/program_loader.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/program_loader_pkg.sv
// Shared types and helpers for the program loader: FSM states, write payload, bank mapping.
package program_loader_pkg;

    localparam int unsigned BYTE_W      = 8;
    localparam int unsigned ADDR_W_DEF  = 16;
    localparam int unsigned BYTE_ADDR_W = 16;
    localparam logic [BYTE_W-1:0] SYNC_BYTE_DEF = 8'hA5;

    // byte_addr[0] selects the bank: 0 = bank 1 (upper byte), 1 = bank 2 (lower byte)
    localparam logic BANK_UPPER = 1'b0;
    localparam logic BANK_LOWER = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR_HI,
        ST_ADDR_LO,
        ST_LEN_HI,
        ST_LEN_LO,
        ST_DATA,
        ST_CSUM,
        ST_DONE
    } state_t;

    typedef struct packed {
        logic [BYTE_ADDR_W-1:0] byte_addr;
        logic [BYTE_W-1:0]      data;
    } wr_req_t;

    // Both banks share one word address; the low byte-address bit only picks the bank.
    function automatic logic [BYTE_ADDR_W-1:0] bank_addr(input logic [BYTE_ADDR_W-1:0] byte_addr);
        return {1'b0, byte_addr[BYTE_ADDR_W-1:1]};
    endfunction

endpackage

// File: rtl/loader_write_port.sv
// Registered bank-write stage: one accepted payload byte becomes a one-cycle strobe
// on the bank chosen by the byte address, with address/data held until the next write.
module loader_write_port
    import program_loader_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_fire,
    input  wr_req_t           wr_req,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [BYTE_W-1:0] mem_data,
    output logic              wr_en_1,
    output logic              wr_en_2
);

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_addr <= '0;
            mem_data <= '0;
            wr_en_1  <= 1'b0;
            wr_en_2  <= 1'b0;
        end else begin
            wr_en_1 <= wr_fire && (wr_req.byte_addr[0] == BANK_UPPER);
            wr_en_2 <= wr_fire && (wr_req.byte_addr[0] == BANK_LOWER);
            if (wr_fire) begin
                mem_addr <= ADDR_W'(bank_addr(wr_req.byte_addr));
                mem_data <= wr_req.data;
            end
        end
    end

endmodule

// File: rtl/program_loader.sv
// Framed byte-stream loader (sync, addr, len, payload) that fills the two data banks
// and holds the CPU while a frame is in flight. Optional trailing checksum: LOADER_CHECKSUM_EN.
module program_loader
    import program_loader_pkg::*;
#(
    parameter logic [7:0]  SYNC_BYTE = SYNC_BYTE_DEF,
    parameter int unsigned ADDR_W    = ADDR_W_DEF
) (
    input  logic              loader_clk,
    input  logic              loader_rst,
    input  logic [7:0]        ld_in_data,
    input  logic              ld_in_valid,
    output logic              ld_in_ready,
    output logic [ADDR_W-1:0] ld_mem_addr,
    output logic [7:0]        ld_mem_data,
    output logic              ld_mem_wr_en_1,
    output logic              ld_mem_wr_en_2,
    output logic              ld_cpu_hold,
    output logic              ld_done,
    output logic              ld_error
);

`ifdef LOADER_CHECKSUM_EN
    localparam state_t TAIL_STATE = ST_CSUM;
`else
    localparam state_t TAIL_STATE = ST_DONE;
`endif

    state_t                 state_q, state_d;
    logic [BYTE_ADDR_W-1:0] byte_addr_q, byte_addr_d;
    logic [15:0]            remaining_q, remaining_d;
    logic [BYTE_W-1:0]      sum_q, sum_d;
    logic                   error_q, error_d;
    logic                   ready_q, hold_q, done_q;
    logic                   accept;
    logic                   wr_fire;
    wr_req_t                wr_req;

    assign accept = ld_in_valid && ready_q;
    assign wr_req = '{byte_addr: byte_addr_q, data: ld_in_data};

    // Next-state and counter updates; every state but DONE advances only on an accepted byte.
    always_comb begin
        state_d     = state_q;
        byte_addr_d = byte_addr_q;
        remaining_d = remaining_q;
        sum_d       = sum_q;
        error_d     = error_q;
        wr_fire     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept && ld_in_data == SYNC_BYTE) begin
                    state_d = ST_ADDR_HI;
                    sum_d   = '0;
                    error_d = 1'b0;
                end
            end
            ST_ADDR_HI: begin
                if (accept) begin
                    byte_addr_d = {ld_in_data, byte_addr_q[7:0]};
                    state_d     = ST_ADDR_LO;
                end
            end
            ST_ADDR_LO: begin
                if (accept) begin
                    byte_addr_d = {byte_addr_q[15:8], ld_in_data};
                    state_d     = ST_LEN_HI;
                end
            end
            ST_LEN_HI: begin
                if (accept) begin
                    remaining_d = {ld_in_data, remaining_q[7:0]};
                    state_d     = ST_LEN_LO;
                end
            end
            ST_LEN_LO: begin
                if (accept) begin
                    remaining_d = {remaining_q[15:8], ld_in_data};
                    state_d     = ({remaining_q[15:8], ld_in_data} == 16'd0) ? TAIL_STATE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (accept) begin
                    wr_fire     = 1'b1;
                    byte_addr_d = byte_addr_q + 16'd1;
                    remaining_d = remaining_q - 16'd1;
                    sum_d       = sum_q + ld_in_data;
                    if (remaining_q == 16'd1) begin
                        state_d = TAIL_STATE;
                    end
                end
            end
`ifdef LOADER_CHECKSUM_EN
            ST_CSUM: begin
                if (accept) begin
                    if (ld_in_data != sum_q) begin
                        error_d = 1'b1;
                    end
                    state_d = ST_DONE;
                end
            end
`endif
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge loader_clk) begin
        if (loader_rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Counters and registered handshake/status outputs, decoded from the upcoming state.
    always_ff @(posedge loader_clk) begin
        if (loader_rst) begin
            byte_addr_q <= '0;
            remaining_q <= '0;
            sum_q       <= '0;
            error_q     <= 1'b0;
            ready_q     <= 1'b1;
            hold_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            byte_addr_q <= byte_addr_d;
            remaining_q <= remaining_d;
            sum_q       <= sum_d;
            error_q     <= error_d;
            ready_q     <= (state_d != ST_DONE);
            hold_q      <= (state_d != ST_IDLE);
            done_q      <= (state_d == ST_DONE);
        end
    end

    assign ld_in_ready = ready_q;
    assign ld_cpu_hold = hold_q;
    assign ld_done     = done_q;
`ifdef LOADER_CHECKSUM_EN
    assign ld_error    = error_q;
`else
    assign ld_error    = 1'b0;
`endif

    loader_write_port #(
        .ADDR_W (ADDR_W)
    ) u_write_port (
        .clk      (loader_clk),
        .rst      (loader_rst),
        .wr_fire  (wr_fire),
        .wr_req   (wr_req),
        .mem_addr (ld_mem_addr),
        .mem_data (ld_mem_data),
        .wr_en_1  (ld_mem_wr_en_1),
        .wr_en_2  (ld_mem_wr_en_2)
    );

endmodule
